dot_product_stream: RTL

Parametrised streaming dot-product engine: accepts VEC_LEN element pairs (a_i, b_i) over a valid/ready input channel, accumulates sum(a_i*b_i) in signed or unsigned mode, and presents one registered result per vector on a valid/ready output channel. It is the successor to the fixed 3-element, 8-bit, free-running dot-product unit, and sits between a sample source (memory reader or UART front-end) and a result consumer that may apply backpressure.

---
 rtl/dp_pkg.sv | 22 ++
 rtl/dp_mac.sv | 37 +++
 rtl/dot_product_stream.sv | 119 +++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared types and width helpers for the streaming dot-product engine.
package dp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } dp_state_t;

    // Result width: full product width plus enough guard bits for vec_len sums.
    function automatic int dp_out_w(input int data_w, input int vec_len);
        return 2 * data_w + $clog2(vec_len);
    endfunction

    // Element index width; a single-pair vector still needs a 1-bit index port.
    localparam int DP_MIN_IDX_W = 1;

    function automatic int dp_idx_w(input int vec_len);
        return (vec_len > 1) ? $clog2(vec_len) : DP_MIN_IDX_W;
    endfunction

endpackage

// File: rtl/dp_mac.sv
// Combinational multiply-accumulate step: product of a and b, extended to
// the accumulator width as signed or unsigned, added to acc_in (or to zero
// on the first pair of a vector).
module dp_mac #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 18
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OUT_W-1:0]  acc_in,
    input  logic              mode,
    input  logic              first,
    output logic [OUT_W-1:0]  acc_out
);

    logic signed [2*DATA_W-1:0] prod_s;
    logic        [2*DATA_W-1:0] prod_u;
    logic        [OUT_W-1:0]    prod_ext;
    logic        [OUT_W-1:0]    acc_base;

    assign prod_s = $signed(a) * $signed(b);
    assign prod_u = a * b;

    // Extend the product to accumulator width according to the vector's mode.
    always_comb begin
        prod_ext = '0;
        if (mode) begin
            prod_ext = OUT_W'(prod_s);
        end else begin
            prod_ext = OUT_W'(prod_u);
        end
    end

    assign acc_base = first ? '0 : acc_in;
    assign acc_out  = acc_base + prod_ext;

endmodule

// File: rtl/dot_product_stream.sv
// Streaming dot-product engine: accepts VEC_LEN (a, b) pairs over a
// valid/ready input, accumulates sum(a*b) in the mode sampled on the first
// pair, and holds the registered result on a valid/ready output.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first pair; samples in_signed into mode_q
// ACCUM | accepting pairs 2..VEC_LEN; bubbles hold acc and idx
// DONE  | result on dout with out_valid; input stalled until handshake
module dot_product_stream
    import dp_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int VEC_LEN = 3,
    parameter int OUT_W   = dp_out_w(DATA_W, VEC_LEN)
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            a_in,
    input  logic [DATA_W-1:0]            b_in,
    input  logic                         in_signed,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUT_W-1:0]             dout,
    output logic [dp_idx_w(VEC_LEN)-1:0] elem_idx
);

    localparam int               IDX_W    = dp_idx_w(VEC_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

    dp_state_t          state_q, state_d;
    logic [OUT_W-1:0]   acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic               mode_q;

    logic               in_xfer;
    logic               last_pair;
    logic               mac_mode;
    logic               mac_first;
    logic [OUT_W-1:0]   mac_sum;

    // in_ready depends only on state, never on out_ready.
    assign in_xfer   = in_valid && (state_q != DONE);
    assign last_pair = (state_q == IDLE) ? (VEC_LEN == 1) : (idx_q == IDX_LAST);
    assign mac_first = (state_q == IDLE);
    assign mac_mode  = (state_q == IDLE) ? in_signed : mode_q;

    dp_mac #(
        .DATA_W (DATA_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .a       (a_in),
        .b       (b_in),
        .acc_in  (acc_q),
        .mode    (mac_mode),
        .first   (mac_first),
        .acc_out (mac_sum)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = last_pair ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && last_pair) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accumulator, element counter and per-vector mode; all updated only on a transfer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q  <= '0;
            idx_q  <= '0;
            mode_q <= 1'b0;
        end else if (in_xfer) begin
            acc_q <= mac_sum;
            if (state_q == IDLE) begin
                mode_q <= in_signed;
            end
            idx_q <= last_pair ? '0 : idx_q + IDX_W'(1);
        end
    end

    assign dout     = acc_q;
    assign elem_idx = idx_q;

endmodule
